// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder: memory-side responder for the page-table walker's PTE port.
// Serves PTE reads and accessed/dirty marks against a 128-bit line memory port.
// A mark is a read-modify-write of one 64-bit PTE inside its 16B line.
// Only one operation is in flight. One further request can wait in a single
// pending slot.
module ptw_mem_responder #(
    parameter int PA_WIDTH    = 32,
    parameter bit SKIP_NOP_WR = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_req_valid,
    input  logic [PA_WIDTH-1:0] mem_req_addr,
    input  logic                mem_req_store,
    input  logic [63:0]         mem_req_data,
    output logic                mem_rsp_valid,
    output logic [63:0]         mem_rsp_data,
    output logic [127:0]        mem_rsp_cacheline,
    input  logic                mem_mark_valid,
    input  logic                mem_mark_accessed,
    input  logic                mem_mark_dirty,
    input  logic [63:0]         mem_mark_addr,
    output logic                mem_mark_rsp_valid,
    output logic                l2_req_valid,
    input  logic                l2_req_ready,
    output logic [PA_WIDTH-1:0] l2_req_addr,
    output logic                l2_req_store,
    output logic [127:0]        l2_req_data,
    input  logic                l2_rsp_valid,
    input  logic [127:0]        l2_rsp_data,
    output logic                proto_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        MK_RD_REQ,
        MK_RD_WAIT,
        MK_WR_REQ,
        MK_WR_WAIT
    } state_t;

    // One queued or starting request: a PTE read or a mark carrying its A/D bits.
    typedef struct packed {
        logic                is_mark;
        logic [PA_WIDTH-1:0] addr;
        logic                a;
        logic                d;
    } op_t;

    state_t state;

    // Pending slot.
    op_t  pend;
    logic pend_valid;

    // The op in flight only needs its word select and its A/D bits.
    // The line address is already held in l2_req_addr.
    logic cur_word;
    logic cur_a;
    logic cur_d;

    op_t  req_in;
    op_t  mark_in;
    op_t  start_op;
    logic is_idle;
    logic start_pend;
    logic start_req;
    logic start_mark;
    logic start_any;
    logic req_cand;
    logic mark_cand;
    logic slot_avail;
    logic slot_take_req;
    logic slot_take_mark;
    logic drop;
    logic stray_rsp;
    logic [63:0]  rd_word;
    logic [63:0]  new_word;
    logic [127:0] new_line;
    logic         nop_mark;

    // Decide what starts this cycle, what goes to the pending slot, and build the marked line.
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no latch can be inferred.
        req_in   = '{is_mark: 1'b0, addr: mem_req_addr, a: 1'b0, d: 1'b0};
        mark_in  = '{is_mark: 1'b1, addr: mem_mark_addr[PA_WIDTH-1:0],
                     a: mem_mark_accessed, d: mem_mark_dirty};

        is_idle    = (state == IDLE);
        // A queued request takes priority over anything that arrives in the same cycle.
        start_pend = is_idle && pend_valid;
        start_req  = is_idle && !pend_valid && mem_req_valid;
        start_mark = is_idle && !pend_valid && !mem_req_valid && mem_mark_valid;
        start_any  = start_pend || start_req || start_mark;
        start_op   = start_pend ? pend : (start_req ? req_in : mark_in);

        // Arrivals that are not started now compete for the single slot. A read wins over a mark.
        req_cand       = mem_req_valid && !start_req;
        mark_cand      = mem_mark_valid && !start_mark;
        slot_avail     = !pend_valid || start_pend;
        slot_take_req  = req_cand && slot_avail;
        slot_take_mark = mark_cand && slot_avail && !req_cand;
        drop           = (req_cand && !slot_avail) || (mark_cand && !slot_take_mark);

        stray_rsp = l2_rsp_valid &&
                    !(state inside {RD_WAIT, MK_RD_WAIT, MK_WR_WAIT});

        rd_word  = cur_word ? l2_rsp_data[127:64] : l2_rsp_data[63:0];
        new_word = rd_word | {56'b0, cur_d, cur_a, 6'b0};
        new_line = cur_word ? {new_word, l2_rsp_data[63:0]}
                            : {l2_rsp_data[127:64], new_word};
        nop_mark = SKIP_NOP_WR && (new_word == rd_word);
    end

    // Ignored request data, address bits above the port width, and the PTE offset within a word.
    logic unused_ok;
    assign unused_ok = ^{mem_req_data, mem_mark_addr[63:PA_WIDTH], start_op.addr[2:0]};

    // Operation FSM with registered outputs, the pending slot and the sticky error flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
        if (reset) begin
            // NOTE: data registers are reset as well, because every output must read 0 after reset.
            state              <= IDLE;
            pend               <= '0;
            pend_valid         <= 1'b0;
            cur_word           <= 1'b0;
            cur_a              <= 1'b0;
            cur_d              <= 1'b0;
            mem_rsp_valid      <= 1'b0;
            mem_rsp_data       <= '0;
            mem_rsp_cacheline  <= '0;
            mem_mark_rsp_valid <= 1'b0;
            l2_req_valid       <= 1'b0;
            l2_req_addr        <= '0;
            l2_req_store       <= 1'b0;
            l2_req_data        <= '0;
            proto_err          <= 1'b0;
        end else begin
            // Completion indications are single-cycle pulses.
            mem_rsp_valid      <= 1'b0;
            mem_mark_rsp_valid <= 1'b0;

            if (drop || (mem_req_valid && mem_req_store) || stray_rsp) begin
                proto_err <= 1'b1;
            end

            if (slot_take_req) begin
                pend       <= req_in;
                pend_valid <= 1'b1;
            end else if (slot_take_mark) begin
                pend       <= mark_in;
                pend_valid <= 1'b1;
            end else if (start_pend) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_any) begin
                        cur_word     <= start_op.addr[3];
                        cur_a        <= start_op.a;
                        cur_d        <= start_op.d;
                        l2_req_valid <= 1'b1;
                        l2_req_store <= 1'b0;
                        l2_req_addr  <= {start_op.addr[PA_WIDTH-1:4], 4'b0};
                        state        <= start_op.is_mark ? MK_RD_REQ : RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (l2_req_ready) begin
                        l2_req_valid <= 1'b0;
                        state        <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (l2_rsp_valid) begin
                        mem_rsp_valid     <= 1'b1;
                        mem_rsp_cacheline <= l2_rsp_data;
                        mem_rsp_data      <= rd_word;
                        state             <= IDLE;
                    end
                end
                MK_RD_REQ: begin
                    if (l2_req_ready) begin
                        l2_req_valid <= 1'b0;
                        state        <= MK_RD_WAIT;
                    end
                end
                MK_RD_WAIT: begin
                    if (l2_rsp_valid) begin
                        if (nop_mark) begin
                            mem_mark_rsp_valid <= 1'b1;
                            state              <= IDLE;
                        end else begin
                            l2_req_valid <= 1'b1;
                            l2_req_store <= 1'b1;
                            l2_req_data  <= new_line;
                            state        <= MK_WR_REQ;
                        end
                    end
                end
                MK_WR_REQ: begin
                    if (l2_req_ready) begin
                        l2_req_valid <= 1'b0;
                        l2_req_store <= 1'b0;
                        state        <= MK_WR_WAIT;
                    end
                end
                MK_WR_WAIT: begin
                    if (l2_rsp_valid) begin
                        mem_mark_rsp_valid <= 1'b1;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// tb_ptw_mem_responder: directed test of the PTE read/mark responder.
// A small line-memory model answers the L2 port.
module tb_ptw_mem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_store;
    logic [63:0]  mem_req_data;
    logic         mem_rsp_valid;
    logic [63:0]  mem_rsp_data;
    logic [127:0] mem_rsp_cacheline;
    logic         mem_mark_valid;
    logic         mem_mark_accessed;
    logic         mem_mark_dirty;
    logic [63:0]  mem_mark_addr;
    logic         mem_mark_rsp_valid;
    logic         l2_req_valid;
    logic         l2_req_ready;
    logic [31:0]  l2_req_addr;
    logic         l2_req_store;
    logic [127:0] l2_req_data;
    logic         l2_rsp_valid;
    logic [127:0] l2_rsp_data;
    logic         proto_err;

    logic         model_rsp_valid;
    logic [127:0] model_rsp_data;
    logic         man_rsp_valid;
    bit           ack_writes;

    logic [127:0] mem [int unsigned];
    logic [32:0]  req_log [$];
    int           nstores;
    int           n_mem_rsp;
    int           total;
    int           bad;

    assign l2_rsp_valid = model_rsp_valid | man_rsp_valid;
    assign l2_rsp_data  = model_rsp_data;

    always #5 clk = ~clk;

    ptw_mem_responder #(.PA_WIDTH(32), .SKIP_NOP_WR(1'b1)) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_addr       (mem_req_addr),
        .mem_req_store      (mem_req_store),
        .mem_req_data       (mem_req_data),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_data       (mem_rsp_data),
        .mem_rsp_cacheline  (mem_rsp_cacheline),
        .mem_mark_valid     (mem_mark_valid),
        .mem_mark_accessed  (mem_mark_accessed),
        .mem_mark_dirty     (mem_mark_dirty),
        .mem_mark_addr      (mem_mark_addr),
        .mem_mark_rsp_valid (mem_mark_rsp_valid),
        .l2_req_valid       (l2_req_valid),
        .l2_req_ready       (l2_req_ready),
        .l2_req_addr        (l2_req_addr),
        .l2_req_store       (l2_req_store),
        .l2_req_data        (l2_req_data),
        .l2_rsp_valid       (l2_rsp_valid),
        .l2_rsp_data        (l2_rsp_data),
        .proto_err          (proto_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge. Requests are single-cycle pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_req_valid     = 1'b0;
        mem_req_store     = 1'b0;
        mem_mark_valid    = 1'b0;
        mem_mark_accessed = 1'b0;
        mem_mark_dirty    = 1'b0;
        man_rsp_valid     = 1'b0;
    endtask

    // which: 0 = mem_rsp_valid, 1 = mem_mark_rsp_valid, 2 = L2 write request valid.
    // Returns the number of cycles waited, or -1 on timeout.
    task automatic wait_sig(input int which, input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if ((which == 0 && mem_rsp_valid) || (which == 1 && mem_mark_rsp_valid) ||
                (which == 2 && l2_req_valid && l2_req_store)) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Line memory: one cycle after acceptance it returns read data or a write ack.
    initial begin
        bit           hit;
        logic         st;
        logic [31:0]  ad;
        logic [127:0] dt;
        model_rsp_valid = 1'b0;
        model_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hit = l2_req_valid && l2_req_ready && !reset;
            st  = l2_req_store;
            ad  = l2_req_addr;
            dt  = l2_req_data;
            @(posedge clk);
            #1;
            model_rsp_valid = 1'b0;
            if (hit) begin
                req_log.push_back({st, ad});
                if (st) begin
                    mem[ad >> 4]    = dt;
                    nstores++;
                    model_rsp_valid = ack_writes;
                    model_rsp_data  = '0;
                end else begin
                    model_rsp_valid = 1'b1;
                    model_rsp_data  = mem.exists(ad >> 4) ? mem[ad >> 4] : '0;
                end
            end
        end
    end

    // Count PTE read responses so the mark tests can confirm none is emitted.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_rsp_valid) n_mem_rsp++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        int c;
        int st0;
        int rs0;
        reset             = 1'b1;
        mem_req_valid     = 1'b0;
        mem_req_addr      = '0;
        mem_req_store     = 1'b0;
        mem_req_data      = '0;
        mem_mark_valid    = 1'b0;
        mem_mark_accessed = 1'b0;
        mem_mark_dirty    = 1'b0;
        mem_mark_addr     = '0;
        l2_req_ready      = 1'b1;
        man_rsp_valid     = 1'b0;
        ack_writes        = 1'b1;

        mem[32'h100] = {64'h0000_0000_AAAA_0001, 64'h0000_0000_BBBB_0001};
        mem[32'h200] = {64'h0123_4567_89AB_CDEF, 64'h0000_0000_2000_0001};
        mem[32'h300] = {64'h0000_0000_0000_00C1, 64'h5555_5555_5555_5555};
        mem[32'h401] = {64'hDEAD_BEEF_0000_0007, 64'h0000_0000_0000_0000};
        mem[32'h500] = {64'h0000_0000_0000_0001, 64'h0000_0000_5000_000F};

        tick();
        tick();
        check("rst_l2_valid", l2_req_valid, 0);
        check("rst_rsp_valid", mem_rsp_valid, 0);
        check("rst_mark_rsp", mem_mark_rsp_valid, 0);
        check("rst_proto_err", proto_err, 0);
        reset = 1'b0;
        tick();

        // 1: read of the upper word, minimum latency
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h1008;
        tick();
        check("t1_l2_valid", l2_req_valid, 1);
        check("t1_l2_addr", l2_req_addr, 32'h1000);
        check("t1_l2_store", l2_req_store, 0);
        tick();
        check("t1_no_rsp_early", mem_rsp_valid, 0);
        tick();
        check("t1_rsp_valid", mem_rsp_valid, 1);
        check("t1_rsp_data", mem_rsp_data, 64'h0000_0000_AAAA_0001);
        check("t1_rsp_line", mem_rsp_cacheline,
              {64'h0000_0000_AAAA_0001, 64'h0000_0000_BBBB_0001});
        tick();
        check("t1_rsp_pulse", mem_rsp_valid, 0);

        // 2: mark A on the low word: write-back of 0x41, upper word unchanged
        st0 = nstores;
        rs0 = n_mem_rsp;
        mem_mark_valid    = 1'b1;
        mem_mark_accessed = 1'b1;
        mem_mark_addr     = 64'h2000;
        wait_sig(2, 10, c);
        check("t2_wr_cycle", c, 3);
        check("t2_wr_addr", l2_req_addr, 32'h2000);
        check("t2_wr_data", l2_req_data, {64'h0123_4567_89AB_CDEF, 64'h0000_0000_2000_0041});
        wait_sig(1, 10, c);
        check("t2_mark_rsp_cycle", c, 2);
        check("t2_mem_line", mem[32'h200], {64'h0123_4567_89AB_CDEF, 64'h0000_0000_2000_0041});
        check("t2_one_store", nstores - st0, 1);
        check("t2_no_mem_rsp", n_mem_rsp - rs0, 0);

        // 3: mark D on an upper-word PTE that already has D set: no store issued
        st0 = nstores;
        mem_mark_valid = 1'b1;
        mem_mark_dirty = 1'b1;
        mem_mark_addr  = 64'h3008;
        wait_sig(1, 10, c);
        check("t3_skip_cycle", c, 3);
        tick();
        tick();
        check("t3_no_store", nstores - st0, 0);
        check("t3_mem_same", mem[32'h300], {64'h0000_0000_0000_00C1, 64'h5555_5555_5555_5555});

        // 4: ready held low for 5 cycles: request stays stable
        l2_req_ready  = 1'b0;
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h4018;
        tick();
        check("t4_valid_0", l2_req_valid, 1);
        check("t4_addr_0", l2_req_addr, 32'h4010);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_valid_hold", l2_req_valid, 1);
            check("t4_addr_hold", l2_req_addr, 32'h4010);
            check("t4_store_hold", l2_req_store, 0);
        end
        l2_req_ready = 1'b1;
        wait_sig(0, 10, c);
        check("t4_rsp_cycle", c, 2);
        check("t4_rsp_data", mem_rsp_data, 64'hDEAD_BEEF_0000_0007);

        // 5: read and mark together, then a third request while the slot is full
        check("t5_err_before", proto_err, 0);
        req_log.delete();
        mem_req_valid     = 1'b1;
        mem_req_addr      = 32'h5000;
        mem_mark_valid    = 1'b1;
        mem_mark_accessed = 1'b1;
        mem_mark_addr     = 64'h6000;
        tick();
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h8000;
        tick();
        check("t5_err_drop", proto_err, 1);
        wait_sig(0, 10, c);
        check("t5_rsp_cycle", c, 1);
        check("t5_rsp_data", mem_rsp_data, 64'h0000_0000_5000_000F);
        tick();
        check("t5_mark_start_valid", l2_req_valid, 1);
        check("t5_mark_start_addr", l2_req_addr, 32'h6000);
        check("t5_mark_start_store", l2_req_store, 0);
        wait_sig(1, 20, c);
        check("t5_mark_done", c > 0, 1);
        check("t5_log_len", req_log.size(), 3);
        if (req_log.size() == 3) begin
            check("t5_log0", req_log[0], {1'b0, 32'h5000});
            check("t5_log1", req_log[1], {1'b0, 32'h6000});
            check("t5_log2", req_log[2], {1'b1, 32'h6000});
        end
        check("t5_mem_line", mem[32'h600], {64'h0, 64'h0000_0000_0000_0040});

        // 6: reset in MK_WR_WAIT, then a late write ack
        ack_writes        = 1'b0;
        mem_mark_valid    = 1'b1;
        mem_mark_accessed = 1'b1;
        mem_mark_addr     = 64'h9000;
        wait_sig(2, 10, c);
        check("t6_wr_cycle", c, 3);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("t6_rsp_valid", mem_rsp_valid, 0);
        check("t6_rsp_data", mem_rsp_data, 0);
        check("t6_rsp_line", mem_rsp_cacheline, 0);
        check("t6_mark_rsp", mem_mark_rsp_valid, 0);
        check("t6_l2_valid", l2_req_valid, 0);
        check("t6_l2_addr", l2_req_addr, 0);
        check("t6_l2_store", l2_req_store, 0);
        check("t6_l2_data", l2_req_data, 0);
        check("t6_proto_err", proto_err, 0);
        reset         = 1'b0;
        man_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_late_no_mark_rsp", mem_mark_rsp_valid, 0);
            check("t6_late_no_l2_req", l2_req_valid, 0);
        end
        ack_writes = 1'b1;

        // 7: a store request is flagged and still served as a read
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("t7_err_clear", proto_err, 0);
        mem_req_valid = 1'b1;
        mem_req_store = 1'b1;
        mem_req_addr  = 32'h1000;
        tick();
        check("t7_l2_store", l2_req_store, 0);
        tick();
        tick();
        check("t7_rsp_valid", mem_rsp_valid, 1);
        check("t7_rsp_data", mem_rsp_data, 64'h0000_0000_BBBB_0001);
        check("t7_proto_err", proto_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
